// File: rtl/rhd_frame_packer.sv
// rhd_frame_packer: serialises RHD convert slots into a framed 16-bit word stream (optional RHD_PACKER_CHECKSUM_EN appends an XOR checksum word); ports: clk/rst, in_valid/in_channel/in_data/in_ready slot input, out_data/out_valid/out_last/out_ready word output, frame_count/drop_count/overflow status
module rhd_frame_packer #(
  parameter int NUM_STREAMS = 32,
  parameter int CHANNELS_PER_FRAME = 35,
  parameter logic [15:0] HEADER_WORD = 16'hA5C3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [7:0] in_channel,
  input  logic [16*NUM_STREAMS-1:0] in_data,
  output logic in_ready,
  output logic [15:0] out_data,
  output logic out_valid,
  output logic out_last,
  input  logic out_ready,
  output logic [31:0] frame_count,
  output logic [15:0] drop_count,
  output logic overflow
);
  localparam int WW = NUM_STREAMS > 1 ? $clog2(NUM_STREAMS) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(NUM_STREAMS - 1);
  localparam logic [7:0] LAST_CH = 8'(CHANNELS_PER_FRAME - 1);
  typedef enum logic [2:0] {IDLE, HDR, CNT_LO, CNT_HI, DATA, CSUM} state_t;
  state_t state_q, state_d;
  logic [16*NUM_STREAMS-1:0] buf_q, buf_d;
  logic [WW-1:0] word_q, word_d;
  logic [31:0] cnt_q, cnt_d, frame_q, frame_d;
  logic [15:0] csum_q, csum_d, drop_q, drop_d;
  logic open_q, open_d, resync_q, resync_d, last_q, last_d, ovf_q, ovf_d;
  logic xfer, word_end, start, cont;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q != IDLE;
  assign xfer = out_valid && out_ready;
  assign word_end = word_q == LAST_W;
  assign start = in_valid && in_ready && in_channel == 8'd0;
  assign cont = in_valid && in_ready && in_channel != 8'd0 && in_channel <= LAST_CH && open_q;
  assign frame_count = frame_q;
  assign drop_count = drop_q;
  assign overflow = ovf_q;
  always_comb begin
    out_data = state_q == HDR    ? HEADER_WORD :
               state_q == CNT_LO ? cnt_q[15:0] :
               state_q == CNT_HI ? cnt_q[31:16] :
               state_q == DATA   ? buf_q[{word_q, 4'b0} +: 16] :
               state_q == CSUM   ? csum_q : 16'd0;
`ifdef RHD_PACKER_CHECKSUM_EN
    out_last = state_q == CSUM;
`else
    out_last = state_q == DATA && word_end && last_q;
`endif
  end
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    word_d = word_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    csum_d = csum_q;
    drop_d = drop_q;
    open_d = open_q;
    resync_d = resync_q;
    last_d = last_q;
    ovf_d = ovf_q;
    if (start) begin
      buf_d = in_data;
      cnt_d = frame_q;
      frame_d = frame_q + 32'd1;
      open_d = 1'b1;
      csum_d = 16'd0;
      word_d = '0;
      last_d = 1'b0;
      state_d = HDR;
    end
    if (cont) begin
      buf_d = in_data;
      word_d = '0;
      last_d = in_channel == LAST_CH;
      state_d = DATA;
    end
    if (in_valid && !in_ready) begin
      ovf_d = 1'b1;
      drop_d = drop_q + {15'd0, drop_q != 16'hFFFF};
      if (in_channel == 8'd0) resync_d = 1'b1;
    end
    if (xfer) begin
      case (state_q)
        HDR:    state_d = CNT_LO;
        CNT_LO: state_d = CNT_HI;
        CNT_HI: state_d = DATA;
        DATA: begin
          csum_d = csum_q ^ out_data;
          word_d = word_q + 1'b1;
          if (word_end) begin
            if (last_q) open_d = 1'b0;
`ifdef RHD_PACKER_CHECKSUM_EN
            state_d = last_q ? CSUM : IDLE;
`else
            state_d = IDLE;
`endif
          end
        end
        CSUM:   state_d = IDLE;
        default: ;
      endcase
    end
    // a channel 0 slot lost to overflow breaks the frame; resync once the current slot has drained
    if (state_q != IDLE && state_d == IDLE && resync_d) begin
      open_d = 1'b0;
      resync_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q <= '0;
      word_q <= '0;
      cnt_q <= '0;
      frame_q <= '0;
      csum_q <= '0;
      drop_q <= '0;
      open_q <= 1'b0;
      resync_q <= 1'b0;
      last_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      word_q <= word_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      csum_q <= csum_d;
      drop_q <= drop_d;
      open_q <= open_d;
      resync_q <= resync_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_rhd_frame_packer.sv
// tb_rhd_frame_packer: randomized self-checking bench against a queue-based frame model
module tb_rhd_frame_packer;
  localparam int NS = 32;
  localparam int CPF = 35;
`ifdef RHD_PACKER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  typedef struct packed {logic [15:0] d; logic l;} wd_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_last, out_ready, overflow;
  logic [7:0] in_channel;
  logic [16*NS-1:0] in_data;
  logic [15:0] out_data, drop_count;
  logic [31:0] frame_count;
  int n_chk = 0, n_fail = 0, mode = 0, pops = 0;
  wd_t q[$];
  logic [31:0] m_fc;
  logic [15:0] m_dc, m_csum;
  logic m_ovf, m_open, m_resync;
  rhd_frame_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_channel(in_channel), .in_data(in_data),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .frame_count(frame_count), .drop_count(drop_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [16*NS-1:0] mk(input int c, input int kind);
    logic [16*NS-1:0] d;
    for (int i = 0; i < NS; i++)
      d[16*i +: 16] = kind == 0 ? 16'(16'h0100 + i) : kind == 1 ? 16'((c << 8) | i) : 16'($urandom);
    return d;
  endfunction
  task automatic model_clear();
    q.delete();
    m_fc = 0; m_dc = 0; m_csum = 0; m_ovf = 0; m_open = 0; m_resync = 0;
  endtask
  task automatic accept(input logic [7:0] c, input logic [16*NS-1:0] d);
    logic [15:0] w;
    if (c == 0) begin
      q.push_back('{16'hA5C3, 1'b0});
      q.push_back('{m_fc[15:0], 1'b0});
      q.push_back('{m_fc[31:16], 1'b0});
      m_fc++;
      m_open = 1;
      m_csum = 0;
    end else if (!m_open || c >= CPF) return;
    for (int i = 0; i < NS; i++) begin
      w = d[16*i +: 16];
      m_csum ^= w;
      q.push_back('{w, c == CPF-1 && i == NS-1 && !CS});
    end
    if (c == CPF-1) begin
      m_open = 0;
      if (CS) q.push_back('{m_csum, 1'b1});
    end
  endtask
  task automatic cyc();
    bit busy;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~out_ready : 1'($urandom_range(0, 1));
    #1;
    busy = q.size() != 0;
    chk("out_valid", 32'(out_valid), 32'(busy));
    if (busy) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_last", 32'(out_last), 32'(q[0].l));
    end
    chk("in_ready", 32'(in_ready), 32'(!busy));
    chk("frame_count", frame_count, m_fc);
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (in_valid) begin
      if (busy) begin
        m_ovf = 1;
        if (m_dc != 16'hFFFF) m_dc++;
        if (in_channel == 0) m_resync = 1;
      end else accept(in_channel, in_data);
    end
    if (busy && out_ready) begin
      void'(q.pop_front());
      pops++;
      if (q.size() == 0 && m_resync) begin
        m_open = 0;
        m_resync = 0;
      end
    end
    @(negedge clk);
  endtask
  task automatic send(input logic [7:0] c, input logic [16*NS-1:0] d);
    in_valid = 1'b1; in_channel = c; in_data = d;
    cyc();
    in_valid = 1'b0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin cyc(); n++; end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);
    cyc();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    model_clear();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_channel = 8'd0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    do_reset();
    mode = 0;
    send(8'd5, mk(5, 2));
    repeat (3) cyc();
    chk("orphan_drops", 32'(drop_count), 0);
    send(8'd0, mk(0, 0));
    drain(100);
    chk("slot0_frames", frame_count, 1);
    do_reset();
    send(8'd0, mk(0, 0));
    repeat (4) cyc();
    send(8'd1, mk(1, 1));
    drain(100);
    chk("ovf_drops", 32'(drop_count), 1);
    chk("ovf_flag", 32'(overflow), 1);
    mode = 1;
    send(8'd0, mk(0, 2));
    drain(200);
    mode = 2;
    for (int c = 0; c < CPF; c++) begin
      send(8'(c), mk(c, 1));
      drain(400);
    end
    send(8'd7, mk(7, 1));
    drain(50);
    mode = 0;
    send(8'd0, mk(0, 2));
    pops = 0;
    for (int n = 0; n < 100 && pops < 10; n++) cyc();
    chk("pre_reset_pops", 32'(pops), 10);
    do_reset();
    send(8'd0, mk(0, 2));
    drain(100);
    for (int k = 0; k < 300; k++) begin
      int c;
      mode = $urandom_range(0, 2);
      c = $urandom_range(0, 9) < 3 ? 0 : $urandom_range(1, 40);
      send(8'(c), mk(c, 2));
      repeat ($urandom_range(0, 40)) cyc();
    end
    drain(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
